lp805x_ntmr_seq: RTL and testbench
==================================

LP805X_NTMR_SEQ -- requirements
Module: lp805x_ntmr_seq

Interface
REQ-001 The block SHALL have parameter RELOAD_RSTVAL, default 16'h0000, giving the reset value of the 16-bit reload register.
REQ-002 The block SHALL have parameter SEQCTR_RSTVAL, default 8'h00, giving the reset value of the sequencer control register.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset sampled on the clk rising edge.
REQ-005 The block SHALL have ports cpu_wr, cpu_wr_bit (input, 1 bit each) and cpu_wr_addr, cpu_data_in (input, 8 bits each): the CPU SFR write request.
REQ-006 The block SHALL have port rd_addr, input, 8 bits: the CPU SFR read address.
REQ-007 The block SHALL have port data_out, output tri, 8 bits: read data, high-Z when not selected.
REQ-008 The block SHALL have port ntf, input, 1 bit: the timer overflow flag.
REQ-009 The block SHALL have ports tmr_wr, tmr_wr_bit (output, 1 bit each) and tmr_wr_addr, tmr_data_in (output, 8 bits each): the arbitrated write port to the timer.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-011 The block SHALL have port irq, output, 1 bit: the reload-done interrupt.

Function
REQ-012 The block SHALL map its own SFRs as: 0xED reload high, 0xEE reload low, 0xEF SEQCTR; byte writes only (cpu_wr=1, cpu_wr_bit=0).
REQ-013 SEQCTR SHALL be laid out as: bit0 ARE (auto-reload enable, RW), bit1 IE (irq enable, RW), bit6 DONE (sticky, write 0 clears), bit7 OVR (sticky, write 0 clears); bits 5:2 SHALL read 0.
REQ-014 The block SHALL keep an 8-bit shadow of every CPU byte write to 0xEC, with reset value 8'h00.
REQ-015 The block SHALL register ntf every cycle into ntf_q; a rising event SHALL be ntf=1 with ntf_q=0.
REQ-016 The FSM SHALL have states IDLE, WR_H, WR_L and CLR_F.
REQ-017 On a rising event with ARE=1 in IDLE, the FSM SHALL go to WR_H on the next edge.
REQ-018 WR_H SHALL issue a byte write of reload[15:8] to 0xEA, then advance to WR_L.
REQ-019 WR_L SHALL issue a byte write of reload[7:0] to 0xEB, then advance to CLR_F.
REQ-020 CLR_F SHALL issue a byte write of (shadow & 8'hFE) to 0xEC, set DONE, then return to IDLE.
REQ-021 The uncontended sequence SHALL take exactly 3 cycles, with the first timer write in the cycle after the rising event is detected.
REQ-022 Arbitration SHALL be combinational and CPU-first: when cpu_wr=1, the tmr_* outputs SHALL equal the cpu_* inputs and the FSM SHALL hold its state, retrying its write in the next free cycle.
REQ-023 When the FSM is idle and there is no CPU write, tmr_wr SHALL be 0 and tmr_wr_bit, tmr_wr_addr and tmr_data_in SHALL be 0.
REQ-024 A CPU write to 0xEA or 0xEB while in WR_H or WR_L SHALL abort the reload and move the FSM to CLR_F; the CPU value SHALL win.
REQ-025 A rising event while not in IDLE SHALL set OVR and SHALL NOT queue a second sequence.
REQ-026 When a CPU write clearing DONE/OVR coincides with a hardware set of the same bit, the hardware set SHALL win.
REQ-027 A CPU write to SEQCTR with ARE=0 during a sequence SHALL NOT abort that sequence.
REQ-028 irq SHALL equal DONE & IE.
REQ-029 Reads SHALL be registered: one cycle after rd_addr equals 0xED, 0xEE or 0xEF, data_out SHALL drive that register; otherwise data_out SHALL be high-Z.

Reset
REQ-030 While rst=0 at a clk edge, the block SHALL force: state IDLE, reload=RELOAD_RSTVAL, SEQCTR=SEQCTR_RSTVAL, shadow=0, ntf_q=0 and the read register=0 (deselected).
REQ-031 From that reset edge, the outputs SHALL be busy=0, irq=0, tmr_wr=0 (unless cpu_wr passes through) and data_out high-Z.
REQ-032 A reset asserted mid-sequence SHALL abandon the sequence with no further timer writes.

Configuration
REQ-033 With macro LP805X_NTMR_SEQ_IRQ_EN defined, IE and irq SHALL behave as specified above.
REQ-034 With LP805X_NTMR_SEQ_IRQ_EN undefined, irq SHALL be tied 0, IE SHALL be unimplemented and read 0, and DONE SHALL still operate.

Verification
REQ-035 Bench: write 0xED=0x12, 0xEE=0x34, 0xEF=0x01, then pulse ntf -> tmr writes EA=12, EB=34, EC=shadow&FE on three consecutive cycles, DONE=1.
REQ-036 Bench: cpu_wr to 0xEC=0x11 in the cycle the FSM is in WR_L -> tmr passes EC=11 that cycle, EB=34 the next cycle, then EC=10; shadow=0x11.
REQ-037 Bench: second ntf rising event while in WR_H -> OVR=1, exactly one sequence issued, 0xEF reads 0xC1.
REQ-038 Bench: CPU write 0xEA=0xAA during WR_H -> no reload writes issued, CLR_F still issued, timer high byte=0xAA.
REQ-039 Bench: IE=1 and the sequence completes -> irq=1; write 0xEF=0x03 -> irq=0; with the macro undefined, irq stays 0 throughout.
REQ-040 Bench: rst=0 while in WR_L -> next cycle busy=0, tmr_wr=0, 0xEF reads SEQCTR_RSTVAL.

Source files
------------

// File: rtl/lp805x_ntmr_seq.sv
// Timer auto-reload sequencer: on a timer overflow it writes the reload value and clears TF through a CPU-first arbitrated SFR port.
// Optional IRQ support is built when LP805X_NTMR_SEQ_IRQ_EN is defined.
module lp805x_ntmr_seq #(
  parameter logic [15:0] RELOAD_RSTVAL = 16'h0000,
  parameter logic [7:0]  SEQCTR_RSTVAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_wr,
  input  logic       cpu_wr_bit,
  input  logic [7:0] cpu_wr_addr,
  input  logic [7:0] cpu_data_in,
  input  logic [7:0] rd_addr,
  output tri   [7:0] data_out,
  input  logic       ntf,
  output logic       tmr_wr,
  output logic       tmr_wr_bit,
  output logic [7:0] tmr_wr_addr,
  output logic [7:0] tmr_data_in,
  output logic       busy,
  output logic       irq
);

  localparam logic [7:0] ADDR_TH   = 8'hEA;
  localparam logic [7:0] ADDR_TL   = 8'hEB;
  localparam logic [7:0] ADDR_TCON = 8'hEC;
  localparam logic [7:0] ADDR_RLH  = 8'hED;
  localparam logic [7:0] ADDR_RLL  = 8'hEE;
  localparam logic [7:0] ADDR_CTR  = 8'hEF;

  typedef enum logic [1:0] {IDLE, WR_H, WR_L, CLR_F} state_t;

  state_t      state_q, state_d;
  logic [15:0] reload_q;
  logic [7:0]  shadow_q;
  logic        are_q, done_q, ovr_q, ntf_q;
  logic        rd_sel_q, rd_hit;
  logic [7:0]  rd_data_q, rd_val, seqctr_rd;
  logic        ie_q;

  logic cpu_byte_wr, wr_rlh, wr_rll, wr_shd, wr_ctr;
  logic rise, reload_abort, set_done, set_ovr;

  assign cpu_byte_wr  = cpu_wr & ~cpu_wr_bit;
  assign wr_rlh       = cpu_byte_wr & (cpu_wr_addr == ADDR_RLH);
  assign wr_rll       = cpu_byte_wr & (cpu_wr_addr == ADDR_RLL);
  assign wr_shd       = cpu_byte_wr & (cpu_wr_addr == ADDR_TCON);
  assign wr_ctr       = cpu_byte_wr & (cpu_wr_addr == ADDR_CTR);
  assign reload_abort = cpu_byte_wr & ((cpu_wr_addr == ADDR_TH) | (cpu_wr_addr == ADDR_TL));
  assign rise         = ntf & ~ntf_q;
  // DONE is set only when the CLR_F write actually reaches the timer port.
  assign set_done     = (state_q == CLR_F) & ~cpu_wr;
  assign set_ovr      = rise & (state_q != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (rise && are_q) state_d = WR_H;
      WR_H:  if (reload_abort) state_d = CLR_F;
             else if (!cpu_wr) state_d = WR_L;
      WR_L:  if (reload_abort || !cpu_wr) state_d = CLR_F;
      CLR_F: if (!cpu_wr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tmr_wr      = 1'b0;
    tmr_wr_bit  = 1'b0;
    tmr_wr_addr = 8'h00;
    tmr_data_in = 8'h00;
    if (cpu_wr) begin
      tmr_wr      = 1'b1;
      tmr_wr_bit  = cpu_wr_bit;
      tmr_wr_addr = cpu_wr_addr;
      tmr_data_in = cpu_data_in;
    end else begin
      unique case (state_q)
        WR_H:  begin tmr_wr = 1'b1; tmr_wr_addr = ADDR_TH;   tmr_data_in = reload_q[15:8]; end
        WR_L:  begin tmr_wr = 1'b1; tmr_wr_addr = ADDR_TL;   tmr_data_in = reload_q[7:0];  end
        CLR_F: begin tmr_wr = 1'b1; tmr_wr_addr = ADDR_TCON; tmr_data_in = shadow_q & 8'hFE; end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      reload_q  <= RELOAD_RSTVAL;
      are_q     <= SEQCTR_RSTVAL[0];
      done_q    <= SEQCTR_RSTVAL[6];
      ovr_q     <= SEQCTR_RSTVAL[7];
      shadow_q  <= 8'h00;
      ntf_q     <= 1'b0;
      rd_sel_q  <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      ntf_q <= ntf;
      if (wr_rlh) reload_q[15:8] <= cpu_data_in;
      if (wr_rll) reload_q[7:0]  <= cpu_data_in;
      if (wr_shd) shadow_q       <= cpu_data_in;
      if (wr_ctr) are_q          <= cpu_data_in[0];
      // Hardware set wins over a coincident CPU clear.
      done_q    <= set_done | (done_q & ~(wr_ctr & ~cpu_data_in[6]));
      ovr_q     <= set_ovr  | (ovr_q  & ~(wr_ctr & ~cpu_data_in[7]));
      rd_sel_q  <= rd_hit;
      rd_data_q <= rd_val;
    end
  end

`ifdef LP805X_NTMR_SEQ_IRQ_EN
  always_ff @(posedge clk) begin
    if (!rst)        ie_q <= SEQCTR_RSTVAL[1];
    else if (wr_ctr) ie_q <= cpu_data_in[1];
  end
  assign irq = done_q & ie_q;
`else
  assign ie_q = 1'b0;
  assign irq  = 1'b0;
`endif

  assign seqctr_rd = {ovr_q, done_q, 4'b0000, ie_q, are_q};

  always_comb begin
    rd_hit = 1'b1;
    rd_val = 8'h00;
    unique case (rd_addr)
      ADDR_RLH: rd_val = reload_q[15:8];
      ADDR_RLL: rd_val = reload_q[7:0];
      ADDR_CTR: rd_val = seqctr_rd;
      default:  rd_hit = 1'b0;
    endcase
  end

  assign data_out = rd_sel_q ? rd_data_q : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_lp805x_ntmr_seq.sv
// Scoreboard bench for lp805x_ntmr_seq: a pending-write-list model predicts the timer port every cycle.
module tb_lp805x_ntmr_seq;

`ifdef LP805X_NTMR_SEQ_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, cpu_wr, cpu_wr_bit, ntf;
  logic [7:0] cpu_wr_addr, cpu_data_in, rd_addr;
  wire  [7:0] data_out;
  logic       tmr_wr, tmr_wr_bit, busy, irq;
  logic [7:0] tmr_wr_addr, tmr_data_in;

  always #5 clk = ~clk;

  lp805x_ntmr_seq dut (
    .clk(clk), .rst(rst), .cpu_wr(cpu_wr), .cpu_wr_bit(cpu_wr_bit),
    .cpu_wr_addr(cpu_wr_addr), .cpu_data_in(cpu_data_in), .rd_addr(rd_addr),
    .data_out(data_out), .ntf(ntf), .tmr_wr(tmr_wr), .tmr_wr_bit(tmr_wr_bit),
    .tmr_wr_addr(tmr_wr_addr), .tmr_data_in(tmr_data_in), .busy(busy), .irq(irq)
  );

  typedef struct packed {
    logic       wr;
    logic       bw;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  logic chk_en = 1'b0;
  logic exp_busy, exp_irq, exp_rd_sel;
  logic [7:0] exp_rd_val;
  logic [7:0] tmr_hi_seen = 8'h00;

  // Reference model: SFR contents plus the list of timer writes still owed by the sequencer.
  logic [15:0] m_reload;
  logic [7:0]  m_shadow, m_rd_val;
  logic        m_are, m_ie, m_done, m_ovr, m_ntf_prev, m_rd_sel;
  int          m_pend[$];   // 0: reload high, 1: reload low, 2: clear TF

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_ctr();
    return {m_ovr, m_done, 4'b0000, m_ie & IRQ_EN, m_are};
  endfunction

  task automatic m_reset();
    m_reload = 16'h0000; m_shadow = 8'h00;
    m_are = 1'b0; m_ie = 1'b0; m_done = 1'b0; m_ovr = 1'b0;
    m_ntf_prev = 1'b0; m_rd_sel = 1'b0; m_rd_val = 8'h00;
    m_pend.delete();
  endtask

  task automatic m_update(input logic r, w, wb, n, input logic [7:0] a, d, ra);
    logic busy_now, rise, set_done, set_ovr, start;
    logic [7:0] ctr_old;
    busy_now = (m_pend.size() > 0);
    rise     = n && !m_ntf_prev;
    set_done = 1'b0;
    set_ovr  = rise && busy_now;
    start    = rise && !busy_now && m_are;
    ctr_old  = m_ctr();
    if (!r) begin
      m_reset();
      return;
    end
    m_rd_sel = (ra == 8'hED) || (ra == 8'hEE) || (ra == 8'hEF);
    m_rd_val = (ra == 8'hED) ? m_reload[15:8] : (ra == 8'hEE) ? m_reload[7:0] :
               (ra == 8'hEF) ? ctr_old : 8'h00;
    if (w) begin
      if (!wb) begin
        case (a)
          8'hED: m_reload[15:8] = d;
          8'hEE: m_reload[7:0]  = d;
          8'hEC: m_shadow       = d;
          8'hEF: begin
            m_are = d[0];
            m_ie  = d[1] & IRQ_EN;
            if (!d[6]) m_done = 1'b0;
            if (!d[7]) m_ovr  = 1'b0;
          end
          8'hEA, 8'hEB: if (busy_now && m_pend[0] != 2) begin
            m_pend.delete();
            m_pend.push_back(2);
          end
          default: ;
        endcase
      end
    end else if (busy_now) begin
      if (m_pend[0] == 2) set_done = 1'b1;
      void'(m_pend.pop_front());
    end
    if (start) m_pend = '{0, 1, 2};
    m_done     = m_done | set_done;
    m_ovr      = m_ovr | set_ovr;
    m_ntf_prev = n;
  endtask

  // One clock cycle: drive inputs, publish this cycle's expected outputs, advance the model.
  task automatic step(input logic r, w, wb, n, input logic [7:0] a, d, ra);
    exp_t e;
    rst = r; cpu_wr = w; cpu_wr_bit = wb; ntf = n;
    cpu_wr_addr = a; cpu_data_in = d; rd_addr = ra;
    e = '0;
    if (w) begin
      e = '{wr: 1'b1, bw: wb, addr: a, data: d};
    end else if (m_pend.size() > 0) begin
      case (m_pend[0])
        0:       e = '{wr: 1'b1, bw: 1'b0, addr: 8'hEA, data: m_reload[15:8]};
        1:       e = '{wr: 1'b1, bw: 1'b0, addr: 8'hEB, data: m_reload[7:0]};
        default: e = '{wr: 1'b1, bw: 1'b0, addr: 8'hEC, data: m_shadow & 8'hFE};
      endcase
    end
    exp_q.push_back(e);
    exp_busy   = (m_pend.size() > 0);
    exp_irq    = m_done & m_ie & IRQ_EN;
    exp_rd_sel = m_rd_sel;
    exp_rd_val = m_rd_val;
    m_update(r, w, wb, n, a, d, ra);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    step(1'b1, 1'b1, 1'b0, 1'b0, a, d, 8'h00);
  endtask

  task automatic rd(input logic [7:0] a);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, a);
  endtask

  task automatic pulse();
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
  endtask

  // Monitor: compares the timer port, busy, irq and read data against the queued expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard: DUT cycle with no expected entry");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("tmr_port", 32'({tmr_wr, tmr_wr_bit, tmr_wr_addr, tmr_data_in}), 32'(e));
      end
      check("busy", 32'(busy), 32'(exp_busy));
      check("irq", 32'(irq), 32'(exp_irq));
      if (exp_rd_sel) check("data_out", 32'(data_out), 32'(exp_rd_val));
      if (tmr_wr && !tmr_wr_bit && tmr_wr_addr == 8'hEA) tmr_hi_seen = tmr_data_in;
    end
  end

  task automatic run_random(input int n);
    logic [7:0] addr_tab [7];
    logic [7:0] rd_tab [4];
    logic [7:0] a, d;
    logic w, wb;
    addr_tab = '{8'hEA, 8'hEB, 8'hEC, 8'hED, 8'hEE, 8'hEF, 8'h90};
    rd_tab   = '{8'hED, 8'hEE, 8'hEF, 8'h00};
    for (int i = 0; i < n; i++) begin
      w  = ($urandom_range(0, 3) == 0);
      wb = w && ($urandom_range(0, 7) == 0);
      a  = addr_tab[$urandom_range(0, 6)];
      d  = 8'($urandom);
      if (a == 8'hEF) d[0] = ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 99) != 0, w, wb, $urandom_range(0, 2) == 0, a, d,
           rd_tab[$urandom_range(0, 3)]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; cpu_wr = 1'b0; cpu_wr_bit = 1'b0; ntf = 1'b0;
    cpu_wr_addr = 8'h00; cpu_data_in = 8'h00; rd_addr = 8'h00;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;

    check("rst_busy", 32'(busy), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_tmr_wr", 32'(tmr_wr), 32'h0);
    rd(8'hEF);
    check("rst_seqctr", 32'(data_out), 32'h00);

    // Basic reload: EA=12, EB=34, EC=00 on consecutive cycles, DONE set.
    wr(8'hED, 8'h12); wr(8'hEE, 8'h34); wr(8'hEF, 8'h01);
    pulse(); idle(4);
    rd(8'hEF);
    check("done_read", 32'(data_out), 32'h41);
    rd(8'hED);
    check("reload_hi_read", 32'(data_out), 32'h12);

    // CPU write to EC during WR_L takes the port; sequence resumes with EB then EC=10.
    pulse(); idle(1); wr(8'hEC, 8'h11); idle(4);

    // Second rising event while held in WR_H sets OVR, only one sequence runs.
    wr(8'hEF, 8'h01);
    pulse();
    wr(8'h90, 8'h55);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    idle(4);
    rd(8'hEF);
    check("ovr_read", 32'(data_out), 32'hC1);

    // CPU write to EA during WR_H aborts the reload writes.
    wr(8'hEF, 8'h01);
    pulse(); wr(8'hEA, 8'hAA); idle(3);
    check("abort_th", 32'(tmr_hi_seen), 32'hAA);

    // Interrupt follows DONE & IE.
    wr(8'hEF, 8'h03);
    pulse(); idle(3);
    check("irq_set", 32'(irq), 32'(IRQ_EN));
    wr(8'hEF, 8'h03);
    check("irq_clr", 32'(irq), 32'h0);

    // Reset in WR_L abandons the sequence.
    wr(8'hEF, 8'h01);
    pulse(); idle(1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_tmr_wr", 32'(tmr_wr), 32'h0);
    rd(8'hEF);
    check("midrst_seqctr", 32'(data_out), 32'h00);

    run_random(600);
    idle(4);
    chk_en = 1'b0;
    check("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
